// File: rtl/eeg_aram_mbank.sv
// eeg_aram_mbank: multi-bank activation RAM controller.
//   Runs one command at a time (WRITE, READ, ACCUM, CLEAR, CONV) over a set of
//   banks selected by a mask, then returns to IDLE.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   IS_IDLE, DONE, ERR        status: idle, command-complete pulse, sticky range error
//   CFG_VLD/RDY/CMD/MASK      command handshake, opcode and bank mask
//   DIN_VLD/LST/RDY/ADD/DAT   per-bank write/accumulate beats
//   ADD_VLD/LST/END/RDY/ADD   per-bank read address beats (END marks CONV completion)
//   DAT_VLD/LST/RDY/DAT       per-bank read data out of a 2-entry skid buffer
module eeg_aram_mbank #(
   parameter int unsigned BANK_NUM = 4,
   parameter int unsigned ADD_AW   = 12,
   parameter int unsigned DAT_DW   = 8,
   parameter int unsigned DEPTH    = 4096,
   parameter int unsigned CMD_DW   = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       IS_IDLE,
   output logic                       DONE,
   output logic                       ERR,
   input  logic                       CFG_VLD,
   output logic                       CFG_RDY,
   input  logic [CMD_DW-1:0]          CFG_CMD,
   input  logic [BANK_NUM-1:0]        CFG_MASK,
   input  logic [BANK_NUM-1:0]        DIN_VLD,
   input  logic [BANK_NUM-1:0]        DIN_LST,
   output logic [BANK_NUM-1:0]        DIN_RDY,
   input  logic [BANK_NUM*ADD_AW-1:0] DIN_ADD,
   input  logic [BANK_NUM*DAT_DW-1:0] DIN_DAT,
   input  logic [BANK_NUM-1:0]        ADD_VLD,
   input  logic [BANK_NUM-1:0]        ADD_LST,
   input  logic [BANK_NUM-1:0]        ADD_END,
   output logic [BANK_NUM-1:0]        ADD_RDY,
   input  logic [BANK_NUM*ADD_AW-1:0] ADD_ADD,
   output logic [BANK_NUM-1:0]        DAT_VLD,
   output logic [BANK_NUM-1:0]        DAT_LST,
   input  logic [BANK_NUM-1:0]        DAT_RDY,
   output logic [BANK_NUM*DAT_DW-1:0] DAT_DAT
);

   localparam logic [CMD_DW-1:0] CMD_WRITE = CMD_DW'(1);
   localparam logic [CMD_DW-1:0] CMD_READ  = CMD_DW'(2);
   localparam logic [CMD_DW-1:0] CMD_ACCUM = CMD_DW'(3);
   localparam logic [CMD_DW-1:0] CMD_CLEAR = CMD_DW'(4);
   localparam logic [CMD_DW-1:0] CMD_CONV  = CMD_DW'(5);
   localparam logic [ADD_AW:0]   DEPTH_W   = (ADD_AW+1)'(DEPTH);
   localparam logic [ADD_AW-1:0] DEPTH_M1  = ADD_AW'(DEPTH-1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_CLR, S_FIN} state_t;

   state_t              state, state_nxt;
   logic [CMD_DW-1:0]   cmd_q;
   logic [BANK_NUM-1:0] mask_q;
   logic [ADD_AW-1:0]   clr_cnt;
   logic                cfg_acc, cmd_legal, err_q;
   logic                run_wr, run_rd, run_acc, run_conv, run_clr;
   logic [BANK_NUM-1:0] done_v, drained_v, oor_v;

   assign IS_IDLE   = (state == S_IDLE);
   assign CFG_RDY   = IS_IDLE;
   assign DONE      = (state == S_FIN);
   assign ERR       = err_q;
   assign cfg_acc   = CFG_VLD & CFG_RDY;
   assign cmd_legal = (CFG_CMD >= CMD_WRITE) && (CFG_CMD <= CMD_CONV);
   assign run_wr    = (state == S_RUN) && (cmd_q == CMD_WRITE);
   assign run_rd    = (state == S_RUN) && (cmd_q == CMD_READ);
   assign run_acc   = (state == S_RUN) && (cmd_q == CMD_ACCUM);
   assign run_conv  = (state == S_RUN) && (cmd_q == CMD_CONV);
   assign run_clr   = (state == S_CLR);

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: if (cfg_acc) begin
            if (!cmd_legal || CFG_MASK == '0) state_nxt = S_FIN;
            else if (CFG_CMD == CMD_CLEAR)     state_nxt = S_CLR;
            else                               state_nxt = S_RUN;
         end
         S_RUN:  if (&done_v && &drained_v) state_nxt = S_FIN;
         S_CLR:  if (clr_cnt == DEPTH_M1)   state_nxt = S_FIN;
         S_FIN:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cmd_q   <= '0;
         mask_q  <= '0;
         clr_cnt <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (cfg_acc) begin
            cmd_q   <= CFG_CMD;
            mask_q  <= CFG_MASK;
            clr_cnt <= '0;
            err_q   <= ~cmd_legal;
         end else begin
            if (run_clr)  clr_cnt <= clr_cnt + 1'b1;
            if (|oor_v)   err_q   <= 1'b1;
         end
      end
   end

   for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
      logic [ADD_AW-1:0] din_add, add_add, rd_idx, wa, s2_add;
      logic [DAT_DW-1:0] din_dat, rd_word, wd, s1_old, s2_old, s2_inc, s2_res;
      logic [DAT_DW:0]   sum;
      logic              din_hs, add_hs, din_oor, add_oor, pop, we, active;
      logic              done, closed, s2_vld, s2_lst, s2_oor;
      logic [DAT_DW-1:0] mem [DEPTH];
      logic [DAT_DW-1:0] sk_dat [2];
      logic [1:0]        sk_lst;
      logic              sk_rp, sk_wp;
      logic [1:0]        sk_cnt, sk_cnt_nxt;

      assign din_add = DIN_ADD[b*ADD_AW +: ADD_AW];
      assign add_add = ADD_ADD[b*ADD_AW +: ADD_AW];
      assign din_dat = DIN_DAT[b*DAT_DW +: DAT_DW];
      assign din_oor = {1'b0, din_add} >= DEPTH_W;
      assign add_oor = {1'b0, add_add} >= DEPTH_W;
      assign active  = mask_q[b] & ~closed;

      assign DIN_RDY[b] = active & (run_wr | run_acc);
      assign ADD_RDY[b] = active & (run_rd | run_conv) & (sk_cnt < 2'd2);
      assign din_hs     = DIN_VLD[b] & DIN_RDY[b];
      assign add_hs     = ADD_VLD[b] & ADD_RDY[b];
      assign pop        = (sk_cnt != 2'd0) & DAT_RDY[b];

      // Only one command runs at a time, so one read port serves both paths.
      assign rd_idx  = run_acc ? din_add : add_add;
      assign rd_word = mem[rd_idx];

      // ACCUM: forward the S2 result when S1 hits the address being written.
      assign s1_old = (s2_vld && !s2_oor && s2_add == din_add) ? s2_res : rd_word;
      assign sum    = {s2_old[DAT_DW-1], s2_old} + {s2_inc[DAT_DW-1], s2_inc};
      always_comb begin
         if (sum[DAT_DW] != sum[DAT_DW-1])
            s2_res = sum[DAT_DW] ? {1'b1, {(DAT_DW-1){1'b0}}} : {1'b0, {(DAT_DW-1){1'b1}}};
         else
            s2_res = sum[DAT_DW-1:0];
      end

      always_comb begin
         we = 1'b0;
         wa = din_add;
         wd = din_dat;
         if (run_clr && mask_q[b]) begin
            we = 1'b1;
            wa = clr_cnt;
            wd = '0;
         end else if (s2_vld && !s2_oor) begin
            we = 1'b1;
            wa = s2_add;
            wd = s2_res;
         end else if (run_wr && din_hs && !din_oor) begin
            we = 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (we) mem[wa] <= wd;
      end

      always_comb begin
         sk_cnt_nxt = sk_cnt;
         if (add_hs && !pop)      sk_cnt_nxt = sk_cnt + 2'd1;
         else if (!add_hs && pop) sk_cnt_nxt = sk_cnt - 2'd1;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            done   <= 1'b0;
            closed <= 1'b0;
            s2_vld <= 1'b0;
            s2_lst <= 1'b0;
            s2_oor <= 1'b0;
            s2_add <= '0;
            s2_old <= '0;
            s2_inc <= '0;
            sk_dat <= '{default: '0};
            sk_lst <= '0;
            sk_rp  <= 1'b0;
            sk_wp  <= 1'b0;
            sk_cnt <= '0;
         end else begin
            s2_vld <= run_acc & din_hs;
            s2_lst <= DIN_LST[b];
            s2_oor <= din_oor;
            s2_add <= din_add;
            s2_old <= s1_old;
            s2_inc <= din_dat;
            if (cfg_acc) begin
               done   <= ~CFG_MASK[b];
               closed <= ~CFG_MASK[b];
            end else begin
               // closed stops further beats once the final one is accepted;
               // done may follow later (ACCUM retire, READ data drain).
               if ((din_hs && DIN_LST[b]) ||
                   (add_hs && ((run_rd && ADD_LST[b]) || (run_conv && ADD_END[b]))))
                  closed <= 1'b1;
               if ((run_wr && din_hs && DIN_LST[b]) || (s2_vld && s2_lst) ||
                   (run_rd && pop && sk_lst[sk_rp]) || (run_conv && add_hs && ADD_END[b]))
                  done <= 1'b1;
            end
            if (add_hs) begin
               sk_dat[sk_wp] <= add_oor ? '0 : rd_word;
               sk_lst[sk_wp] <= ADD_LST[b];
               sk_wp         <= ~sk_wp;
            end
            if (pop) sk_rp <= ~sk_rp;
            sk_cnt <= sk_cnt_nxt;
         end
      end

      assign DAT_VLD[b]                   = (sk_cnt != 2'd0);
      assign DAT_LST[b]                   = (sk_cnt != 2'd0) & sk_lst[sk_rp];
      assign DAT_DAT[b*DAT_DW +: DAT_DW]  = sk_dat[sk_rp];
      assign done_v[b]                    = done;
      // Lets RUN->FIN happen in the same cycle the last skid word leaves.
      assign drained_v[b]                 = (sk_cnt_nxt == 2'd0);
      assign oor_v[b]                     = (din_hs & din_oor) | (add_hs & add_oor);
   end

endmodule

// File: tb/tb_eeg_aram_mbank.sv
// tb_eeg_aram_mbank: scoreboard bench for eeg_aram_mbank.
//   Read expectations are queued per bank from a bench-side RAM model when an
//   address beat is accepted, and compared when the data handshake occurs.
module tb_eeg_aram_mbank;
   localparam int NB = 4;
   localparam int AW = 6;
   localparam int DW = 8;
   localparam int DP = 40;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            IS_IDLE, DONE, ERR, CFG_RDY;
   logic            CFG_VLD = 1'b0;
   logic [2:0]      CFG_CMD = '0;
   logic [NB-1:0]   CFG_MASK = '0;
   logic [NB-1:0]   DIN_VLD = '0, DIN_LST = '0, DIN_RDY;
   logic [NB*AW-1:0] DIN_ADD = '0;
   logic [NB*DW-1:0] DIN_DAT = '0;
   logic [NB-1:0]   ADD_VLD = '0, ADD_LST = '0, ADD_END = '0, ADD_RDY;
   logic [NB*AW-1:0] ADD_ADD = '0;
   logic [NB-1:0]   DAT_VLD, DAT_LST;
   logic [NB-1:0]   DAT_RDY = '0;
   logic [NB*DW-1:0] DAT_DAT;

   int checks = 0;
   int failures = 0;
   int rdy_bad = 0;
   logic watch = 1'b0;
   logic [DW-1:0] mdl [NB][DP];
   logic [DW:0]   sbq [NB][$];

   eeg_aram_mbank #(.BANK_NUM(NB), .ADD_AW(AW), .DAT_DW(DW), .DEPTH(DP), .CMD_DW(3)) dut (
      .clk(clk), .rst(rst), .IS_IDLE(IS_IDLE), .DONE(DONE), .ERR(ERR),
      .CFG_VLD(CFG_VLD), .CFG_RDY(CFG_RDY), .CFG_CMD(CFG_CMD), .CFG_MASK(CFG_MASK),
      .DIN_VLD(DIN_VLD), .DIN_LST(DIN_LST), .DIN_RDY(DIN_RDY), .DIN_ADD(DIN_ADD), .DIN_DAT(DIN_DAT),
      .ADD_VLD(ADD_VLD), .ADD_LST(ADD_LST), .ADD_END(ADD_END), .ADD_RDY(ADD_RDY), .ADD_ADD(ADD_ADD),
      .DAT_VLD(DAT_VLD), .DAT_LST(DAT_LST), .DAT_RDY(DAT_RDY), .DAT_DAT(DAT_DAT)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] sat8(input logic [DW-1:0] a, input logic [DW-1:0] b);
      int s;
      s = int'($signed(a)) + int'($signed(b));
      if (s > 127) s = 127;
      else if (s < -128) s = -128;
      return s[DW-1:0];
   endfunction

   // Scoreboard consumer and port-idle watcher.
   always @(negedge clk) begin
      if (!rst) begin
         for (int b = 0; b < NB; b++) begin
            if (DAT_VLD[b] && DAT_RDY[b]) begin
               check("sb_has_entry", (sbq[b].size() != 0), 1);
               if (sbq[b].size() != 0)
                  check($sformatf("rd_dat_b%0d", b), {DAT_LST[b], DAT_DAT[b*DW +: DW]}, sbq[b].pop_front());
            end
         end
      end
      if (watch && (ADD_RDY[1] | ADD_RDY[3] | DIN_RDY[1] | DIN_RDY[3])) rdy_bad++;
   end

   task automatic cfg(input logic [2:0] cmd, input logic [NB-1:0] mask);
      check("cfg_rdy", CFG_RDY, 1);
      CFG_VLD = 1'b1; CFG_CMD = cmd; CFG_MASK = mask;
      @(posedge clk); #1;
      CFG_VLD = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp_n);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!DONE && n < 200);
      check({tag, "_done_lat"}, n, exp_n);
      @(negedge clk);
      check({tag, "_done_pulse"}, DONE, 0);
      check({tag, "_idle"}, IS_IDLE, 1);
   endtask

   task automatic din_beat(input int b, input int addr, input logic [DW-1:0] dat,
                           input logic lst, input logic acc);
      int n;
      DIN_VLD[b] = 1'b1; DIN_LST[b] = lst;
      DIN_ADD[b*AW +: AW] = AW'(addr); DIN_DAT[b*DW +: DW] = dat;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!DIN_RDY[b] && n < 50);
      check("din_rdy", DIN_RDY[b], 1);
      if (addr < DP) mdl[b][addr] = acc ? sat8(mdl[b][addr], dat) : dat;
      @(posedge clk); #1;
      DIN_VLD[b] = 1'b0; DIN_LST[b] = 1'b0;
   endtask

   task automatic rd_beat(input int b, input int addr, input logic lst, input logic endf);
      int n;
      ADD_VLD[b] = 1'b1; ADD_LST[b] = lst; ADD_END[b] = endf;
      ADD_ADD[b*AW +: AW] = AW'(addr);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ADD_RDY[b] && n < 50);
      check("add_rdy", ADD_RDY[b], 1);
      sbq[b].push_back({lst, (addr < DP) ? mdl[b][addr] : 8'h00});
      @(posedge clk); #1;
      ADD_VLD[b] = 1'b0; ADD_LST[b] = 1'b0; ADD_END[b] = 1'b0;
   endtask

   initial begin
      int n;
      // Reset state
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_idle", IS_IDLE, 1);
      check("rst_cfg_rdy", CFG_RDY, 1);
      check("rst_done", DONE, 0);
      check("rst_err", ERR, 0);
      check("rst_rdy", {DIN_RDY, ADD_RDY}, 0);
      check("rst_vld", {DAT_VLD, DAT_LST}, 0);
      check("rst_dat", DAT_DAT, 0);
      rst = 1'b0;

      // WRITE bank0, then READ back addr 5
      cfg(3'd1, 4'b0001);
      din_beat(0, 3, 8'h70, 1'b0, 1'b0);
      din_beat(0, 7, 8'h05, 1'b0, 1'b0);
      din_beat(0, 9, 8'h90, 1'b0, 1'b0);
      din_beat(0, 5, 8'h12, 1'b1, 1'b0);
      wait_done("wr", 2);
      check("wr_err", ERR, 0);
      DAT_RDY = '1;
      cfg(3'd2, 4'b0001);
      rd_beat(0, 5, 1'b1, 1'b0);
      @(negedge clk);
      check("rd_lat_vld", DAT_VLD[0], 1);
      check("rd_lat_dat", DAT_DAT[DW-1:0], 8'h12);
      n = 0;
      do begin @(negedge clk); n++; end while (!DONE && n < 200);
      check("rd_done_lat", n + 1, 3);
      @(negedge clk);
      check("rd_done_pulse", DONE, 0);

      // ACCUM back-to-back, forwarding and saturation both ways
      cfg(3'd3, 4'b0001);
      din_beat(0, 7, 8'h03, 1'b0, 1'b1);
      din_beat(0, 7, 8'h04, 1'b0, 1'b1);
      din_beat(0, 3, 8'h10, 1'b0, 1'b1);
      din_beat(0, 3, 8'h10, 1'b0, 1'b1);
      din_beat(0, 9, 8'hE0, 1'b1, 1'b1);
      wait_done("acc", 3);
      check("acc_mdl_sat", mdl[0][3], 8'h7F);

      // Illegal command goes straight to FIN and flags ERR
      cfg(3'd7, 4'b0001);
      wait_done("ill", 1);
      check("ill_err", ERR, 1);

      // READ with back-pressure: skid fills, then drains in order
      DAT_RDY[0] = 1'b0;
      cfg(3'd2, 4'b0001);
      check("cfg_clears_err", ERR, 0);
      rd_beat(0, 3, 1'b0, 1'b0);
      rd_beat(0, 7, 1'b0, 1'b0);
      @(negedge clk);
      check("skid_full_rdy", ADD_RDY[0], 0);
      repeat (3) @(negedge clk);
      check("skid_hold_vld", DAT_VLD[0], 1);
      check("skid_hold_dat", DAT_DAT[DW-1:0], 8'h7F);
      DAT_RDY[0] = 1'b1;
      rd_beat(0, 9, 1'b1, 1'b0);
      wait_done("bp", 3);

      // CONV on banks 0 and 2, simultaneous END; bank2 address out of range
      watch = 1'b1;
      cfg(3'd5, 4'b0101);
      rd_beat(0, 7, 1'b0, 1'b0);
      ADD_VLD = 4'b0101; ADD_END = 4'b0101; ADD_LST = 4'b0101;
      ADD_ADD[0 +: AW] = AW'(5); ADD_ADD[2*AW +: AW] = AW'(45);
      n = 0;
      do begin @(negedge clk); n++; end while (!(ADD_RDY[0] && ADD_RDY[2]) && n < 50);
      check("conv_rdy", {ADD_RDY[2], ADD_RDY[0]}, 2'b11);
      sbq[0].push_back({1'b1, mdl[0][5]});
      sbq[2].push_back({1'b1, 8'h00});
      @(posedge clk); #1;
      ADD_VLD = '0; ADD_END = '0; ADD_LST = '0;
      wait_done("conv", 2);
      watch = 1'b0;
      check("conv_idle_banks", rdy_bad, 0);
      check("conv_oor_err", ERR, 1);

      // CLEAR bank1 after seeding it, then read back incl. addr DEPTH
      cfg(3'd1, 4'b0010);
      din_beat(1, 0, 8'h55, 1'b0, 1'b0);
      din_beat(1, DP - 1, 8'h66, 1'b1, 1'b0);
      wait_done("wr1", 2);
      cfg(3'd4, 4'b0010);
      for (int a = 0; a < DP; a++) mdl[1][a] = 8'h00;
      wait_done("clr", DP + 1);
      check("clr_err", ERR, 0);
      cfg(3'd2, 4'b0010);
      rd_beat(1, 0, 1'b0, 1'b0);
      rd_beat(1, DP - 1, 1'b0, 1'b0);
      rd_beat(1, DP, 1'b1, 1'b0);
      wait_done("clr_rd", 3);
      check("clr_rd_err", ERR, 1);

      // Reset mid-READ with two words held in the skid
      DAT_RDY = '0;
      cfg(3'd2, 4'b0001);
      rd_beat(0, 3, 1'b0, 1'b0);
      rd_beat(0, 5, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sbq[0].delete();
      @(negedge clk);
      check("mid_rst_vld", DAT_VLD, 0);
      check("mid_rst_idle", IS_IDLE, 1);
      check("mid_rst_err", ERR, 0);

      for (int b = 0; b < NB; b++) check($sformatf("sb_empty_b%0d", b), sbq[b].size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
